// File: rtl/fir_pkg.sv
// Shared constants and helpers for the FIR result drain path.
package fir_pkg;

  localparam int SUM_W = 32;
  localparam int OUT_W = 16;

  localparam logic [OUT_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [OUT_W-1:0] SAT_NEG = 16'h8000;

  // Ceiling log2, used to size pointers and occupancy counters.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int p = 32'sd1; p < value; p = p * 32'sd2) begin
      res = res + 32'sd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_drain_fifo.sv
// Show-ahead synchronous FIFO for the drain path. The head word is
// presented on rdata_o whenever the FIFO is not empty; an empty FIFO
// presents zero. A push into a full FIFO is accepted only when a pop
// happens in the same cycle.
module fir_drain_fifo
  import fir_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [clog2(DEPTH):0]  level_o
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   lvl_q, lvl_d;
  logic          rd_en_s;
  logic          wr_en_s;

  assign empty_o = (lvl_q == '0);
  assign full_o  = (lvl_q == FULL_LVL);
  assign level_o = lvl_q;
  assign rd_en_s = pop_i & ~empty_o;
  assign wr_en_s = push_i & (~full_o | rd_en_s);

  // Head word, forced to zero while empty so stale entries never leak out.
  always_comb begin
    rdata_o = '0;
    if (empty_o) begin
      rdata_o = '0;
    end else begin
      rdata_o = mem_q[rd_q];
    end
  end

  // Next pointer and occupancy values from the accepted push/pop pair.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (wr_en_s) begin
      wr_d = wr_q + PTR_ONE;
    end else begin
      wr_d = wr_q;
    end
    if (rd_en_s) begin
      rd_d = rd_q + PTR_ONE;
    end else begin
      rd_d = rd_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   lvl_d = lvl_q + LVL_ONE;
      2'b01:   lvl_d = lvl_q - LVL_ONE;
      default: lvl_d = lvl_q;
    endcase
  end

  // Storage and pointer registers; reset discards all contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (wr_en_s) begin
        mem_q[wr_q] <= wdata_i;
      end
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

endmodule

// File: rtl/fir_result_drain.sv
// Reader side of the FIR core result stream (clk3 domain).
// Samples DA sums on a strobe, scales by SHIFT, saturates to 16 bits,
// buffers the samples and hands them downstream on valid/ready.
// Build option: FIR_DRAIN_ROUND_EN selects round-half-up scaling;
// without it the scaling truncates toward minus infinity.
module fir_result_drain
  import fir_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int SHIFT  = 15,
  parameter int DROP_W = 8
) (
  input  logic                  clk3,
  input  logic                  areset_n,
  input  logic [SUM_W-1:0]      sum_in,
  input  logic                  sum_valid,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [clog2(DEPTH):0] level,
  output logic [DROP_W-1:0]     drop_count,
  input  logic                  drop_clr
);

  // Saturation limits sign-extended to the 33-bit working width.
  localparam logic signed [SUM_W:0] POS_LIM =
    $signed({{(SUM_W+1-OUT_W){1'b0}}, SAT_POS});
  localparam logic signed [SUM_W:0] NEG_LIM =
    $signed({{(SUM_W+1-OUT_W){1'b1}}, SAT_NEG});
`ifdef FIR_DRAIN_ROUND_EN
  localparam logic signed [SUM_W:0] RND = 33'sd1 <<< (SHIFT - 1);
`endif
  localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1'b1);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  // One extra bit keeps the rounding add from wrapping near +2^31.
  function automatic logic [OUT_W-1:0] scale_sat(input logic [SUM_W-1:0] sum);
    logic signed [SUM_W:0] t;
    logic signed [SUM_W:0] r;
    t = $signed({sum[SUM_W-1], sum});
`ifdef FIR_DRAIN_ROUND_EN
    t = t + RND;
`endif
    r = t >>> SHIFT;
    if (r > POS_LIM) begin
      return SAT_POS;
    end else if (r < NEG_LIM) begin
      return SAT_NEG;
    end else begin
      return r[OUT_W-1:0];
    end
  endfunction

  logic [OUT_W-1:0]  stg_data_q, stg_data_d;
  logic              stg_v_q, stg_v_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              pop_s;
  logic              drop_s;

  assign out_valid  = ~fifo_empty_s;
  assign pop_s      = out_valid & out_ready;
  assign drop_s     = stg_v_q & fifo_full_s & ~pop_s;
  assign drop_count = drop_q;

  // Stage register: capture the scaled sample on the strobe.
  always_comb begin
    stg_v_d    = sum_valid;
    stg_data_d = stg_data_q;
    if (sum_valid) begin
      stg_data_d = scale_sat(sum_in);
    end else begin
      stg_data_d = stg_data_q;
    end
  end

  // Drop counter: saturating; a clear coinciding with a drop leaves one.
  always_comb begin
    drop_d = drop_q;
    if (drop_clr) begin
      if (drop_s) begin
        drop_d = DROP_ONE;
      end else begin
        drop_d = '0;
      end
    end else if (drop_s && (drop_q != DROP_MAX)) begin
      drop_d = drop_q + DROP_ONE;
    end else begin
      drop_d = drop_q;
    end
  end

  // Stage and drop-counter state registers.
  always_ff @(posedge clk3 or negedge areset_n) begin
    if (!areset_n) begin
      stg_data_q <= '0;
      stg_v_q    <= 1'b0;
      drop_q     <= '0;
    end else begin
      stg_data_q <= stg_data_d;
      stg_v_q    <= stg_v_d;
      drop_q     <= drop_d;
    end
  end

  fir_drain_fifo #(
    .DEPTH (DEPTH),
    .W     (OUT_W)
  ) u_fifo (
    .clk_i   (clk3),
    .rst_ni  (areset_n),
    .push_i  (stg_v_q),
    .pop_i   (pop_s),
    .wdata_i (stg_data_q),
    .rdata_o (out_data),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (level)
  );

endmodule
